// File: rtl/id_ex_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg_pkg
// Description : Shared widths and control-bundle types for the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_reg_pkg;

    localparam int C_DATA_W     = 32;
    localparam int C_REG_ADDR_W = 5;
    localparam int C_ALUOP_W    = 2;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic reg_dst;
        logic alu_src;
    } ctrl_flags_t;

    typedef struct packed {
        ctrl_flags_t            flags;
        logic [C_ALUOP_W-1:0]   alu_op;
    } ctrl_t;

    // Side-effecting controls are forced low for a non-instruction slot.
    function automatic ctrl_flags_t gate_ctrl(input ctrl_flags_t f, input logic valid);
        ctrl_flags_t g;
        g           = f;
        g.reg_write = f.reg_write & valid;
        g.mem_read  = f.mem_read  & valid;
        g.mem_write = f.mem_write & valid;
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_reg_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Flags a load in EX whose destination is a source of the ID op.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  valid_ex,
    input  logic                  mem_read_ex,
    input  logic [REG_ADDR_W-1:0] rt_ex,
    input  logic                  valid_id,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    output logic                  hazard
);

    logic w_rt_nonzero;
    logic w_match;

    // Register zero is hardwired, so a load targeting it never creates a hazard.
    assign w_rt_nonzero = |rt_ex;
    assign w_match      = (rt_ex == rs_id) | (rt_ex == rt_id);
    assign hazard       = valid_ex & mem_read_ex & w_rt_nonzero & valid_id & w_match;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register with stall, flush and optional
//               load-use bubble insertion (macro ID_EX_HAZARD_DETECT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W     = C_DATA_W,
    parameter int REG_ADDR_W = C_REG_ADDR_W,
    parameter int ALUOP_W    = C_ALUOP_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic                  valid_in,
    input  logic                  RegWrite_In,
    input  logic                  MemtoReg_In,
    input  logic                  MemRead_In,
    input  logic                  MemWrite_In,
    input  logic                  RegDst_In,
    input  logic                  ALUSrc_In,
    input  logic [ALUOP_W-1:0]    ALUOp_In,
    input  logic [REG_ADDR_W-1:0] Rs_In,
    input  logic [REG_ADDR_W-1:0] Rt_In,
    input  logic [REG_ADDR_W-1:0] Rd_In,
    input  logic [DATA_W-1:0]     Read_Data_1_In,
    input  logic [DATA_W-1:0]     Read_Data_2_In,
    input  logic [DATA_W-1:0]     Sign_Extend_In,
    output logic                  valid_out,
    output logic                  RegWrite_Out,
    output logic                  MemtoReg_Out,
    output logic                  MemRead_Out,
    output logic                  MemWrite_Out,
    output logic                  RegDst_Out,
    output logic                  ALUSrc_Out,
    output logic [ALUOP_W-1:0]    ALUOp_Out,
    output logic [REG_ADDR_W-1:0] Rs_Out,
    output logic [REG_ADDR_W-1:0] Rt_Out,
    output logic [REG_ADDR_W-1:0] Rd_Out,
    output logic [DATA_W-1:0]     Read_Data_1_Out,
`ifdef ID_EX_HAZARD_DETECT_EN
    output logic                  hazard_stall,
`endif
    output logic [DATA_W-1:0]     Read_Data_2_Out,
    output logic [DATA_W-1:0]     Sign_Extend_Out
);

    ctrl_flags_t               w_ctrl_in;
    ctrl_flags_t               r_ctrl;
    logic                      r_valid;
    logic [ALUOP_W-1:0]        r_alu_op;
    logic [REG_ADDR_W-1:0]     r_rs;
    logic [REG_ADDR_W-1:0]     r_rt;
    logic [REG_ADDR_W-1:0]     r_rd;
    logic [DATA_W-1:0]         r_rd1;
    logic [DATA_W-1:0]         r_rd2;
    logic [DATA_W-1:0]         r_sext;
    logic                      w_load_use;

    assign w_ctrl_in.reg_write  = RegWrite_In;
    assign w_ctrl_in.mem_to_reg = MemtoReg_In;
    assign w_ctrl_in.mem_read   = MemRead_In;
    assign w_ctrl_in.mem_write  = MemWrite_In;
    assign w_ctrl_in.reg_dst    = RegDst_In;
    assign w_ctrl_in.alu_src    = ALUSrc_In;

`ifdef ID_EX_HAZARD_DETECT_EN
    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .valid_ex    (r_valid),
        .mem_read_ex (r_ctrl.mem_read),
        .rt_ex       (r_rt),
        .valid_id    (valid_in),
        .rs_id       (Rs_In),
        .rt_id       (Rt_In),
        .hazard      (w_load_use)
    );
    assign hazard_stall = w_load_use;
`else
    assign w_load_use = 1'b0;
`endif

    // A bubble clears every control bit but leaves specifiers and operands intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_ctrl   <= '0;
            r_alu_op <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_sext   <= '0;
        end else if (flush_in) begin
            r_valid  <= 1'b0;
            r_ctrl   <= '0;
            r_alu_op <= '0;
        end else if (stall_in) begin
            r_valid  <= r_valid;
        end else if (w_load_use) begin
            r_valid  <= 1'b0;
            r_ctrl   <= '0;
            r_alu_op <= '0;
        end else begin
            r_valid  <= valid_in;
            r_ctrl   <= gate_ctrl(w_ctrl_in, valid_in);
            r_alu_op <= ALUOp_In;
            r_rs     <= Rs_In;
            r_rt     <= Rt_In;
            r_rd     <= Rd_In;
            r_rd1    <= Read_Data_1_In;
            r_rd2    <= Read_Data_2_In;
            r_sext   <= Sign_Extend_In;
        end
    end

    assign valid_out       = r_valid;
    assign RegWrite_Out    = r_ctrl.reg_write;
    assign MemtoReg_Out    = r_ctrl.mem_to_reg;
    assign MemRead_Out     = r_ctrl.mem_read;
    assign MemWrite_Out    = r_ctrl.mem_write;
    assign RegDst_Out      = r_ctrl.reg_dst;
    assign ALUSrc_Out      = r_ctrl.alu_src;
    assign ALUOp_Out       = r_alu_op;
    assign Rs_Out          = r_rs;
    assign Rt_Out          = r_rt;
    assign Rd_Out          = r_rd;
    assign Read_Data_1_Out = r_rd1;
    assign Read_Data_2_Out = r_rd2;
    assign Sign_Extend_Out = r_sext;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_reg
// Description : Directed scoreboard bench for id_ex_stage_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic        rdst;
        logic        asrc;
        logic [1:0]  aluop;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] se;
    } out_t;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush_in, valid_in;
    logic        RegWrite_In, MemtoReg_In, MemRead_In, MemWrite_In, RegDst_In, ALUSrc_In;
    logic [1:0]  ALUOp_In;
    logic [4:0]  Rs_In, Rt_In, Rd_In;
    logic [31:0] Read_Data_1_In, Read_Data_2_In, Sign_Extend_In;
    logic        valid_out, RegWrite_Out, MemtoReg_Out, MemRead_Out, MemWrite_Out;
    logic        RegDst_Out, ALUSrc_Out;
    logic [1:0]  ALUOp_Out;
    logic [4:0]  Rs_Out, Rt_Out, Rd_Out;
    logic [31:0] Read_Data_1_Out, Read_Data_2_Out, Sign_Extend_Out;
    logic        hz_obs;

    int   checks = 0;
    int   errors = 0;
    out_t model;
    out_t obs;
    out_t sb_q[$];

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk             (clk),
        .reset           (reset),
        .stall_in        (stall_in),
        .flush_in        (flush_in),
        .valid_in        (valid_in),
        .RegWrite_In     (RegWrite_In),
        .MemtoReg_In     (MemtoReg_In),
        .MemRead_In      (MemRead_In),
        .MemWrite_In     (MemWrite_In),
        .RegDst_In       (RegDst_In),
        .ALUSrc_In       (ALUSrc_In),
        .ALUOp_In        (ALUOp_In),
        .Rs_In           (Rs_In),
        .Rt_In           (Rt_In),
        .Rd_In           (Rd_In),
        .Read_Data_1_In  (Read_Data_1_In),
        .Read_Data_2_In  (Read_Data_2_In),
        .Sign_Extend_In  (Sign_Extend_In),
        .valid_out       (valid_out),
        .RegWrite_Out    (RegWrite_Out),
        .MemtoReg_Out    (MemtoReg_Out),
        .MemRead_Out     (MemRead_Out),
        .MemWrite_Out    (MemWrite_Out),
        .RegDst_Out      (RegDst_Out),
        .ALUSrc_Out      (ALUSrc_Out),
        .ALUOp_Out       (ALUOp_Out),
        .Rs_Out          (Rs_Out),
        .Rt_Out          (Rt_Out),
        .Rd_Out          (Rd_Out),
        .Read_Data_1_Out (Read_Data_1_Out),
`ifdef ID_EX_HAZARD_DETECT_EN
        .hazard_stall    (hz_obs),
`endif
        .Read_Data_2_Out (Read_Data_2_Out),
        .Sign_Extend_Out (Sign_Extend_Out)
    );

`ifndef ID_EX_HAZARD_DETECT_EN
    assign hz_obs = 1'b0;
`endif

    assign obs = '{valid_out, RegWrite_Out, MemtoReg_Out, MemRead_Out, MemWrite_Out,
                   RegDst_Out, ALUSrc_Out, ALUOp_Out, Rs_Out, Rt_Out, Rd_Out,
                   Read_Data_1_Out, Read_Data_2_Out, Sign_Extend_Out};

    function automatic logic model_hazard(input out_t m);
`ifdef ID_EX_HAZARD_DETECT_EN
        return m.valid && m.mr && (m.rt != 5'd0) && valid_in &&
               ((m.rt == Rs_In) || (m.rt == Rt_In));
`else
        return 1'b0;
`endif
    endfunction

    function automatic out_t model_next(input out_t m);
        out_t n;
        n = m;
        if (reset) begin
            n = '0;
        end else if (flush_in || (!stall_in && model_hazard(m))) begin
            n.valid = 0; n.rw = 0; n.m2r = 0; n.mr = 0; n.mw = 0;
            n.rdst = 0; n.asrc = 0; n.aluop = 2'b00;
        end else if (!stall_in) begin
            n.valid = valid_in;
            n.rw    = RegWrite_In & valid_in;
            n.m2r   = MemtoReg_In;
            n.mr    = MemRead_In & valid_in;
            n.mw    = MemWrite_In & valid_in;
            n.rdst  = RegDst_In;
            n.asrc  = ALUSrc_In;
            n.aluop = ALUOp_In;
            n.rs    = Rs_In;
            n.rt    = Rt_In;
            n.rd    = Rd_In;
            n.d1    = Read_Data_1_In;
            n.d2    = Read_Data_2_In;
            n.se    = Sign_Extend_In;
        end
        return n;
    endfunction

    task automatic check_hazard(input string tag, input logic exp);
        checks++;
        assert (hz_obs === exp) else begin
            errors++;
            $error("FAIL %s hazard_stall observed=%b expected=%b", tag, hz_obs, exp);
        end
    endtask

    // Inputs are already applied; push expectation, clock once, then compare.
    task automatic step(input string tag);
        out_t exp;
        #1;
        model = model_next(model);
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; stall_in = 0; flush_in = 0; valid_in = 0;
        RegWrite_In = 0; MemtoReg_In = 0; MemRead_In = 0; MemWrite_In = 0;
        RegDst_In = 0; ALUSrc_In = 0; ALUOp_In = 2'b00;
        Rs_In = 0; Rt_In = 0; Rd_In = 0;
        Read_Data_1_In = 0; Read_Data_2_In = 0; Sign_Extend_In = 0;
    endtask

    task automatic set_all_ones();
        valid_in = 1; RegWrite_In = 1; MemtoReg_In = 1; MemRead_In = 1; MemWrite_In = 1;
        RegDst_In = 1; ALUSrc_In = 1; ALUOp_In = 2'b11;
        Rs_In = 5'h1F; Rt_In = 5'h1F; Rd_In = 5'h1F;
        Read_Data_1_In = 32'hFFFF_FFFF; Read_Data_2_In = 32'hFFFF_FFFF;
        Sign_Extend_In = 32'hFFFF_FFFF;
    endtask

    initial begin
        model = '1;
        idle_inputs();
        set_all_ones();
        reset = 1;
        step("reset_all_ones_in");
        reset = 0;
        idle_inputs();
        #1 check_hazard("hazard_after_reset", 1'b0);

        // Basic load
        valid_in = 1; Read_Data_1_In = 32'h0000_1234; Rd_In = 5'd7; RegWrite_In = 1;
        step("load_basic");

        // Full-width load
        set_all_ones();
        MemRead_In = 0; Rt_In = 5'd3; Rs_In = 5'd9;
        step("load_full_width");

        // Gating of side-effecting controls for an invalid slot
        set_all_ones();
        valid_in = 0;
        step("gated_invalid");

        // Stall holds contents for three cycles
        idle_inputs();
        valid_in = 1; Read_Data_1_In = 32'hAAAA_5555; Read_Data_2_In = 32'h5555_AAAA;
        Sign_Extend_In = 32'h0000_0F0F; Rd_In = 5'd12; RegWrite_In = 1; ALUOp_In = 2'b10;
        step("load_pre_stall");
        set_all_ones();
        MemRead_In = 0;
        stall_in = 1;
        step("stall_1");
        step("stall_2");
        step("stall_3");
        stall_in = 0;

        // Flush and stall together
        idle_inputs();
        valid_in = 1; MemWrite_In = 1; Read_Data_2_In = 32'hDEAD_BEEF; Rs_In = 5'd2;
        step("load_store");
        set_all_ones();
        MemRead_In = 0;
        flush_in = 1; stall_in = 1;
        step("flush_with_stall");
        flush_in = 0; stall_in = 0;

        // Reset during stall
        idle_inputs();
        valid_in = 1; Read_Data_1_In = 32'h1; RegWrite_In = 1;
        step("load_one");
        stall_in = 1; reset = 1;
        step("reset_mid_stall");
        reset = 0; stall_in = 0;
        Read_Data_1_In = 32'h2;
        step("load_after_reset");
        reset = 1; flush_in = 1;
        step("reset_mid_flush");
        reset = 0; flush_in = 0;

        // Load-use: lw writing r5 followed by a consumer of r5
        idle_inputs();
        valid_in = 1; MemRead_In = 1; MemtoReg_In = 1; RegWrite_In = 1; ALUSrc_In = 1;
        Rt_In = 5'd5; Rs_In = 5'd1; Sign_Extend_In = 32'h0000_0010;
        step("load_lw_r5");
        idle_inputs();
        valid_in = 1; Rs_In = 5'd5; Rt_In = 5'd6; Rd_In = 5'd8; RegWrite_In = 1;
        RegDst_In = 1; Read_Data_1_In = 32'h0000_0055;
`ifdef ID_EX_HAZARD_DETECT_EN
        #1 check_hazard("hazard_rs_match", 1'b1);
`else
        #1 check_hazard("no_hazard_port", 1'b0);
`endif
        step("after_lw_consumer");
        #1 check_hazard("hazard_cleared", 1'b0);
        step("consumer_retry");

        // Load targeting r0 never raises a hazard
        idle_inputs();
        valid_in = 1; MemRead_In = 1; Rt_In = 5'd0;
        step("load_lw_r0");
        idle_inputs();
        valid_in = 1; Rs_In = 5'd0; Rt_In = 5'd0; Read_Data_2_In = 32'h0000_0077;
        #1 check_hazard("hazard_rt_zero", 1'b0);
        step("after_lw_r0");

        // Stall takes priority over a detected load-use
        idle_inputs();
        valid_in = 1; MemRead_In = 1; Rt_In = 5'd9;
        step("load_lw_r9");
        idle_inputs();
        valid_in = 1; Rt_In = 5'd9; stall_in = 1;
        step("stall_over_hazard");
        stall_in = 0;
        step("hazard_after_stall");

        if (sb_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
